// File: rtl/synapse_current_gen.sv
// rtl/synapse_current_gen.sv - presynaptic current generator: per-step decay plus saturating weighted spike sum
module synapse_current_gen #(
    parameter int N_PRE       = 8,
    parameter int W_WIDTH     = 12,
    parameter int DECAY_SHIFT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     step,
    input  logic [N_PRE-1:0]         spikes_in,
    input  logic                     w_we,
    input  logic [$clog2(N_PRE)-1:0] w_addr,
    input  logic [W_WIDTH-1:0]       w_data,
    output logic [15:0]              current_out,
    output logic                     current_valid,
    output logic                     busy
);
    localparam int AW = $clog2(N_PRE);
    localparam logic [AW:0]   ADDR_LIM = (AW+1)'(N_PRE);
    localparam logic [AW-1:0] LAST_IDX = AW'(N_PRE - 1);

    typedef enum logic [1:0] {IDLE, DECAY, ACCUM, DONE} state_t;

    state_t             state;
    logic [15:0]        acc;
    logic [N_PRE-1:0]   snap;
    logic [AW-1:0]      idx;
    logic [W_WIDTH-1:0] weights [N_PRE];
    logic [16:0]        sum;
    logic [15:0]        acc_add;

    // The weight read uses the pre-edge table, so a same-cycle write to idx lands next step.
    assign sum = {1'b0, acc} + {{(17-W_WIDTH){1'b0}}, weights[idx]};

    always_comb begin
        acc_add = acc;
        if (snap[idx]) acc_add = sum[16] ? 16'hFFFF : sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            acc           <= '0;
            snap          <= '0;
            idx           <= '0;
            current_out   <= '0;
            current_valid <= 1'b0;
            busy          <= 1'b0;
            for (int i = 0; i < N_PRE; i++) weights[i] <= '0;
        end else begin
            if (w_we && ({1'b0, w_addr} < ADDR_LIM)) weights[w_addr] <= w_data;
            case (state)
                IDLE: begin
                    if (step) begin
                        snap  <= spikes_in;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= DECAY;
                    end
                end
                DECAY: begin
                    // Truncating shift: currents below 2^DECAY_SHIFT hold steady.
                    acc   <= acc - (acc >> DECAY_SHIFT);
                    state <= ACCUM;
                end
                ACCUM: begin
                    acc <= acc_add;
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        current_out   <= acc_add;
                        current_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    current_valid <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
